// File: rtl/reg_file_reader.sv
// MIPS architectural register file: 32 x DATA_WIDTH, $zero hardwired,
// one synchronous write port, two combinational read ports with same-cycle
// write bypass, plus a valid/ready dump streamer that snapshots every
// register (0..31) without ever stalling the datapath.
module reg_file_reader #(
  parameter int DATA_WIDTH = 64,
  parameter int REG_COUNT  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [4:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [4:0]            rs_addr,
  output logic [DATA_WIDTH-1:0] rs_data,
  input  logic [4:0]            rt_addr,
  output logic [DATA_WIDTH-1:0] rt_data,
  input  logic                  dump_start,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [4:0]            dump_addr,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic                  dump_busy,
  output logic                  dump_done
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] regs [REG_COUNT];
  logic                  hs, last;
  logic [4:0]            nxt_addr;
  logic [DATA_WIDTH-1:0] nxt_data;

  // dump_addr doubles as the beat index: it always equals idx.
  assign hs       = (state == SEND) && dump_ready;
  assign last     = (dump_addr == 5'd31);
  assign nxt_addr = dump_addr + 5'd1;

  // Next beat must reflect a write landing on the same edge that accepts
  // the current beat, so it goes through the bypass too. nxt_addr is never
  // 0 when used (the last beat does not load a successor).
  assign nxt_data = (wr_en && wr_addr == nxt_addr) ? wr_data : regs[nxt_addr];

  // Read ports: $zero, then write bypass, then stored value.
  assign rs_data = (rs_addr == 5'd0) ? '0 :
                   (wr_en && wr_addr == rs_addr) ? wr_data : regs[rs_addr];
  assign rt_data = (rt_addr == 5'd0) ? '0 :
                   (wr_en && wr_addr == rt_addr) ? wr_data : regs[rt_addr];

  assign dump_valid = (state == SEND);
  assign dump_busy  = (state == SEND);

  // Register array write port; index 0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (wr_en && wr_addr != 5'd0) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Dump FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Dump FSM next-state: start only from IDLE, finish on the last handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (dump_start)  state_nxt = SEND;
      SEND: if (hs && last)  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Beat registers: loaded on start or on handshake, held during a stall so
  // the presented beat is a snapshot even if its register is rewritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dump_addr <= '0;
      dump_data <= '0;
      dump_done <= 1'b0;
    end else begin
      dump_done <= hs && last;
      if (state == IDLE && dump_start) begin
        dump_addr <= '0;
        dump_data <= '0;
      end else if (hs && !last) begin
        dump_addr <= nxt_addr;
        dump_data <= nxt_data;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_reader.sv
// Self-checking bench for reg_file_reader: directed scenarios followed by a
// randomized phase, all compared against a behavioural model of the
// register file and the dump stream.
module tb_reg_file_reader;

  logic        clk, rst_n;
  logic        wr_en;
  logic [4:0]  wr_addr, rs_addr, rt_addr, dump_addr;
  logic [63:0] wr_data, rs_data, rt_data, dump_data;
  logic        dump_start, dump_valid, dump_ready, dump_busy, dump_done;

  int nvec = 0;
  int nerr = 0;

  // Model state
  logic [63:0] m_regs [32];
  logic        m_busy, m_done;
  logic [4:0]  m_addr;
  logic [63:0] m_data;

  int busy_cnt, done_cnt, beat_cnt;

  reg_file_reader #(.DATA_WIDTH(64), .REG_COUNT(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rs_addr(rs_addr), .rs_data(rs_data),
    .rt_addr(rt_addr), .rt_data(rt_data),
    .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data),
    .dump_busy(dump_busy), .dump_done(dump_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mread(input logic [4:0] a);
    if (a == 0) return 64'd0;
    if (wr_en && wr_addr == a) return wr_data;
    return m_regs[a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
    m_busy = 1'b0; m_done = 1'b0; m_addr = 5'd0; m_data = 64'd0;
  endtask

  // Compare every observable output with the model, after inputs settle.
  task automatic check_all();
    #1;
    chk("rs_data", rs_data, mread(rs_addr));
    chk("rt_data", rt_data, mread(rt_addr));
    chk("dump_valid", {63'd0, dump_valid}, {63'd0, m_busy});
    chk("dump_busy", {63'd0, dump_busy}, {63'd0, m_busy});
    chk("dump_done", {63'd0, dump_done}, {63'd0, m_done});
    if (m_busy) begin
      chk("dump_addr", {59'd0, dump_addr}, {59'd0, m_addr});
      chk("dump_data", dump_data, m_data);
    end
  endtask

  // Advance one clock; model computes what the edge should produce.
  task automatic tick();
    logic [63:0] nregs [32];
    logic        hs, n_busy, n_done;
    logic [4:0]  n_addr;
    logic [63:0] n_data;
    nregs = m_regs;
    if (wr_en && wr_addr != 0) nregs[wr_addr] = wr_data;
    hs     = m_busy && dump_ready;
    n_done = hs && (m_addr == 5'd31);
    n_busy = m_busy; n_addr = m_addr; n_data = m_data;
    if (!m_busy && dump_start) begin
      n_busy = 1'b1; n_addr = 5'd0; n_data = 64'd0;
    end else if (hs) begin
      if (m_addr == 5'd31) n_busy = 1'b0;
      else begin
        n_addr = m_addr + 5'd1;
        n_data = nregs[n_addr];
      end
    end
    @(posedge clk); #1;
    if (rst_n) begin
      m_regs = nregs; m_busy = n_busy; m_done = n_done;
      m_addr = n_addr; m_data = n_data;
    end
  endtask

  task automatic drain();
    dump_ready = 1'b1;
    for (int n = 0; n < 80 && (dump_busy || dump_done); n++) begin
      check_all(); tick();
    end
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 0; wr_addr = 0; wr_data = 0; rs_addr = 0; rt_addr = 0;
    dump_start = 0; dump_ready = 0;
    m_reset();
    #12;
    chk("rst_valid", {63'd0, dump_valid}, 64'd0);
    chk("rst_busy", {63'd0, dump_busy}, 64'd0);
    chk("rst_done", {63'd0, dump_done}, 64'd0);
    chk("rst_addr", {59'd0, dump_addr}, 64'd0);
    chk("rst_data", dump_data, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Basic write / read, and dropped write to $zero
    wr_en = 1; wr_addr = 5; wr_data = 64'hDEAD; check_all(); tick();
    wr_en = 0; rs_addr = 5; check_all();
    chk("read5", rs_data, 64'hDEAD);
    wr_en = 1; wr_addr = 0; wr_data = 64'hFFFF; check_all(); tick();
    wr_en = 0; rs_addr = 0; check_all();
    chk("read0", rs_data, 64'd0);

    // Same-cycle bypass on both ports
    wr_en = 1; wr_addr = 7; wr_data = 64'h1234; rs_addr = 7; rt_addr = 7;
    #1;
    chk("bypass_rs", rs_data, 64'h1234);
    chk("bypass_rt", rt_data, 64'h1234);
    tick();

    // Setup reg[i] = i*0x10
    for (int i = 1; i < 32; i++) begin
      wr_en = 1; wr_addr = i[4:0]; wr_data = 64'(i * 16); rs_addr = i[4:0];
      check_all(); tick();
    end
    wr_en = 0;

    // Full dump at full throughput
    dump_ready = 1; dump_start = 1; check_all(); tick(); dump_start = 0;
    busy_cnt = 0; done_cnt = 0; beat_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      check_all();
      if (dump_busy) busy_cnt++;
      if (dump_done) done_cnt++;
      if (dump_valid) begin
        chk("beat_addr", {59'd0, dump_addr}, 64'(beat_cnt));
        chk("beat_data", dump_data, 64'(beat_cnt * 16));
        beat_cnt++;
      end
      tick();
    end
    chk("busy_cycles", 64'(busy_cnt), 64'd32);
    chk("done_pulses", 64'(done_cnt), 64'd1);

    // Backpressure with snapshot on beat 3
    dump_start = 1; check_all(); tick(); dump_start = 0;
    for (int n = 0; n < 40 && !(dump_valid && dump_addr == 5'd3); n++) begin
      check_all(); tick();
    end
    chk("reach3", {59'd0, dump_addr}, 64'd3);
    dump_ready = 0; wr_en = 1; wr_addr = 3; wr_data = 64'hBEEF;
    check_all(); tick(); wr_en = 0;
    check_all();
    chk("snap_hold", dump_data, 64'h30);
    tick(); check_all();
    chk("snap_hold2", dump_data, 64'h30);
    drain();
    dump_start = 1; check_all(); tick(); dump_start = 0;
    for (int n = 0; n < 40 && !(dump_valid && dump_addr == 5'd3); n++) begin
      check_all(); tick();
    end
    chk("snap_new", dump_data, 64'hBEEF);
    drain();

    // Next-beat bypass: accept beat 9 while writing reg 10
    dump_start = 1; check_all(); tick(); dump_start = 0;
    for (int n = 0; n < 40 && !(dump_valid && dump_addr == 5'd9); n++) begin
      check_all(); tick();
    end
    wr_en = 1; wr_addr = 10; wr_data = 64'hABC; check_all(); tick(); wr_en = 0;
    check_all();
    chk("nb_addr", {59'd0, dump_addr}, 64'd10);
    chk("nb_data", dump_data, 64'hABC);
    drain();

    // Abort mid-dump with asynchronous reset
    dump_start = 1; check_all(); tick(); dump_start = 0;
    for (int n = 0; n < 5; n++) begin check_all(); tick(); end
    #3 rst_n = 1'b0;
    #1;
    m_reset();
    chk("abort_valid", {63'd0, dump_valid}, 64'd0);
    chk("abort_busy", {63'd0, dump_busy}, 64'd0);
    chk("abort_done", {63'd0, dump_done}, 64'd0);
    for (int i = 0; i < 32; i++) begin
      rs_addr = i[4:0]; rt_addr = 5'(31 - i); #0.1;
      chk("abort_rs", rs_data, 64'd0);
      chk("abort_rt", rt_data, 64'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin check_all(); tick(); end
    dump_start = 1; check_all(); tick(); dump_start = 0;
    check_all();
    chk("restart_addr", {59'd0, dump_addr}, 64'd0);
    chk("restart_valid", {63'd0, dump_valid}, 64'd1);
    drain();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      wr_en      = ($urandom_range(0, 1) == 1);
      wr_addr    = 5'($urandom_range(0, 31));
      wr_data    = {$urandom, $urandom};
      rs_addr    = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      rt_addr    = 5'($urandom_range(0, 31));
      dump_start = ($urandom_range(0, 7) == 0);
      dump_ready = ($urandom_range(0, 3) != 0);
      check_all(); tick();
    end
    wr_en = 0; dump_start = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
